game_controller: RTL and testbench

- Turn-level controller for the 8x8 five-in-a-row game.
- Sits directly upstream of the move judger and owns the board-memory write port.
- Turns debounced key pulses into cursor moves and place requests, and runs one judge transaction per place request.
- On a legal move it writes the piece into board memory, updates the step count, and either toggles the side to move or ends the game. Also clears the board at reset and on restart.

---
 rtl/game_controller_pkg.sv | 28 ++
 rtl/game_controller_cursor_ctrl.sv | 40 ++++
 rtl/game_controller.sv | 193 +++++++++++++++++++
 tb/tb_game_controller.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_controller_pkg.sv
// Shared constants, state encoding and helpers for the game turn controller.
package game_controller_pkg;

    localparam logic       SIDE_RED       = 1'b0;
    localparam logic       SIDE_GREEN     = 1'b1;

    localparam logic [1:0] JUDGER_INVALID = 2'b00;
    localparam logic [1:0] JUDGER_VALID   = 2'b01;
    localparam logic [1:0] JUDGER_WIN     = 2'b10;

    localparam logic [1:0] CELL_EMPTY     = 2'b00;
    localparam logic [1:0] CELL_RED       = 2'b10;
    localparam logic [1:0] CELL_GREEN     = 2'b01;

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_PLAY  = 3'd1,
        S_JUDGE = 3'd2,
        S_WRITE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // Board-memory code for a piece of the given side.
    function automatic logic [1:0] side_cell(input logic side);
        return (side == SIDE_GREEN) ? CELL_GREEN : CELL_RED;
    endfunction

endpackage

// File: rtl/game_controller_cursor_ctrl.sv
// Wrap-around 8x8 cursor; opposing keys on the same axis cancel.
module cursor_ctrl #(
    parameter logic [5:0] CURSOR_INIT = 6'd27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_init,
    input  logic       move_en,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    output logic [5:0] pos
);

    logic [2:0] x_next;
    logic [2:0] y_next;

    // Next coordinates: 3-bit arithmetic gives the mod-8 wrap for free.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        x_next = pos[2:0];
        y_next = pos[5:3];
        if (move_en) begin
            if (key_right && !key_left)      x_next = pos[2:0] + 3'd1;
            else if (key_left && !key_right) x_next = pos[2:0] - 3'd1;
            if (key_down && !key_up)         y_next = pos[5:3] + 3'd1;
            else if (key_up && !key_down)    y_next = pos[5:3] - 3'd1;
        end
    end

    // Cursor register; restart reloads the centre position.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n)         pos <= CURSOR_INIT;
        else if (load_init) pos <= CURSOR_INIT;
        else                pos <= {y_next, x_next};
    end

endmodule

// File: rtl/game_controller.sv
// Turn-level controller: board clear, cursor, judge and memory-write handshakes.
module game_controller
    import game_controller_pkg::*;
#(
    parameter int         BOARD_CELLS = 64,
    parameter logic [5:0] CURSOR_INIT = 6'd27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_place,
    input  logic       key_restart,
    output logic       judge_en,
    output logic       judge_color,
    output logic [5:0] judge_pos,
    input  logic [1:0] judge_result,
    input  logic       judge_done,
    output logic       mem_wr_en,
    output logic [5:0] mem_wr_addr,
    output logic [1:0] mem_wr_data,
    input  logic       mem_wr_ack,
    output logic [5:0] cursor_pos,
    output logic       cur_side,
    output logic [6:0] step_count,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [5:0] CLEAR_LAST = 6'(BOARD_CELLS - 1);
    localparam logic [6:0] CELLS_W    = 7'(BOARD_CELLS);

    state_t     state, state_next;
    logic [5:0] clr_addr, clr_addr_next;
    logic       judge_win, judge_win_next;
    logic       restart_pending, restart_pending_next;
    logic       judge_en_next, mem_wr_en_next, judge_color_next, cur_side_next, game_over_next;
    logic [5:0] judge_pos_next;
    logic [6:0] step_count_next;
    logic [1:0] winner_next;
    logic       cursor_load, cursor_move, go_clear;

    cursor_ctrl #(.CURSOR_INIT(CURSOR_INIT)) u_cursor (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_init (cursor_load),
        .move_en   (cursor_move),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .pos       (cursor_pos)
    );

    // The clear loop owns the write port in S_CLEAR; otherwise it carries the judged move.
    assign mem_wr_addr = (state == S_CLEAR) ? clr_addr : judge_pos;
    assign mem_wr_data = (state == S_CLEAR) ? CELL_EMPTY : side_cell(judge_color);

    // Next-state and next-register logic for the turn FSM.
    always_comb begin
        state_next           = state;
        clr_addr_next        = clr_addr;
        judge_en_next        = judge_en;
        mem_wr_en_next       = mem_wr_en;
        judge_pos_next       = judge_pos;
        judge_color_next     = judge_color;
        judge_win_next       = judge_win;
        restart_pending_next = restart_pending;
        cur_side_next        = cur_side;
        step_count_next      = step_count;
        game_over_next       = game_over;
        winner_next          = winner;
        cursor_load          = 1'b0;
        cursor_move          = 1'b0;
        go_clear             = 1'b0;

        case (state)
            S_CLEAR: begin
                // One handshake per address, with a gap so each address is a separate request.
                if (!mem_wr_en) begin
                    mem_wr_en_next = 1'b1;
                end else if (mem_wr_ack) begin
                    mem_wr_en_next = 1'b0;
                    if (clr_addr == CLEAR_LAST) state_next = S_PLAY;
                    else                        clr_addr_next = clr_addr + 6'd1;
                end
            end
            S_PLAY: begin
                if (key_restart) begin
                    go_clear = 1'b1;
                end else begin
                    cursor_move = 1'b1;
                    // Place uses the pre-move cursor; a stale judge_done blocks a new request.
                    if (key_place && !judge_done) begin
                        judge_pos_next   = cursor_pos;
                        judge_color_next = cur_side;
                        judge_en_next    = 1'b1;
                        state_next       = S_JUDGE;
                    end
                end
            end
            S_JUDGE: begin
                if (key_restart) restart_pending_next = 1'b1;
                if (judge_en && judge_done) begin
                    judge_en_next  = 1'b0;
                    judge_win_next = (judge_result == JUDGER_WIN);
                    if (judge_result == JUDGER_VALID || judge_result == JUDGER_WIN) begin
                        // A legal move is always committed, even with a restart pending.
                        state_next     = S_WRITE;
                        mem_wr_en_next = 1'b1;
                    end else if (restart_pending || key_restart) begin
                        go_clear = 1'b1;
                    end else begin
                        state_next = S_PLAY;
                    end
                end
            end
            S_WRITE: begin
                if (key_restart) restart_pending_next = 1'b1;
                if (mem_wr_en && mem_wr_ack) begin
                    mem_wr_en_next  = 1'b0;
                    step_count_next = step_count + 7'd1;
                    if (restart_pending || key_restart) begin
                        go_clear = 1'b1;
                    end else if (judge_win) begin
                        state_next     = S_OVER;
                        game_over_next = 1'b1;
                        winner_next    = side_cell(judge_color);
                    end else if (step_count + 7'd1 == CELLS_W) begin
                        state_next     = S_OVER;
                        game_over_next = 1'b1;
                        winner_next    = CELL_EMPTY;
                    end else begin
                        cur_side_next = ~cur_side;
                        state_next    = S_PLAY;
                    end
                end
            end
            S_OVER: begin
                if (key_restart) go_clear = 1'b1;
            end
            default: state_next = S_CLEAR;
        endcase

        // Restart overrides whatever the state above chose.
        if (go_clear) begin
            state_next           = S_CLEAR;
            clr_addr_next        = 6'd0;
            judge_en_next        = 1'b0;
            mem_wr_en_next       = 1'b0;
            restart_pending_next = 1'b0;
            cur_side_next        = SIDE_RED;
            step_count_next      = 7'd0;
            game_over_next       = 1'b0;
            winner_next          = CELL_EMPTY;
            cursor_load          = 1'b1;
        end
    end

    // State and registered outputs; reset drops both request lines at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_CLEAR;
            clr_addr        <= 6'd0;
            judge_en        <= 1'b0;
            mem_wr_en       <= 1'b0;
            judge_pos       <= 6'd0;
            judge_color     <= SIDE_RED;
            judge_win       <= 1'b0;
            restart_pending <= 1'b0;
            cur_side        <= SIDE_RED;
            step_count      <= 7'd0;
            game_over       <= 1'b0;
            winner          <= CELL_EMPTY;
        end else begin
            state           <= state_next;
            clr_addr        <= clr_addr_next;
            judge_en        <= judge_en_next;
            mem_wr_en       <= mem_wr_en_next;
            judge_pos       <= judge_pos_next;
            judge_color     <= judge_color_next;
            judge_win       <= judge_win_next;
            restart_pending <= restart_pending_next;
            cur_side        <= cur_side_next;
            step_count      <= step_count_next;
            game_over       <= game_over_next;
            winner          <= winner_next;
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller with judger and memory responders.
module tb_game_controller;
    import game_controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic       key_place = 1'b0, key_restart = 1'b0;
    logic       judge_en, judge_color;
    logic [5:0] judge_pos;
    logic [1:0] judge_result = 2'b00;
    logic       judge_done = 1'b0;
    logic       mem_wr_en;
    logic [5:0] mem_wr_addr;
    logic [1:0] mem_wr_data;
    logic       mem_wr_ack = 1'b0;
    logic [5:0] cursor_pos;
    logic       cur_side;
    logic [6:0] step_count;
    logic       game_over;
    logic [1:0] winner;

    always #5 clk = ~clk;

    game_controller dut (
        .clk(clk), .rst_n(rst_n),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .key_place(key_place), .key_restart(key_restart),
        .judge_en(judge_en), .judge_color(judge_color), .judge_pos(judge_pos),
        .judge_result(judge_result), .judge_done(judge_done),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack),
        .cursor_pos(cursor_pos), .cur_side(cur_side), .step_count(step_count),
        .game_over(game_over), .winner(winner)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Responder configuration and observation logs.
    int         ack_delay = 0;
    int         judge_delay = 0;
    logic [1:0] next_result = JUDGER_INVALID;
    logic [7:0] wr_q[$];
    int         judge_count = 0;
    logic [5:0] last_jpos = 6'd0;
    logic       last_jcolor = 1'b0;
    int         stable_err = 0;
    int         inv_err = 0;

    // Memory: acks after ack_delay cycles, logs {addr,data}, checks request stability.
    initial begin : mem_model
        int         wait_cnt;
        logic       hold_valid;
        logic [7:0] hold;
        wait_cnt = 0; hold_valid = 1'b0; hold = 8'd0;
        forever begin
            @(negedge clk);
            if (mem_wr_ack) begin
                mem_wr_ack = 1'b0;
            end else if (mem_wr_en) begin
                if (hold_valid && {mem_wr_addr, mem_wr_data} !== hold) stable_err++;
                hold = {mem_wr_addr, mem_wr_data};
                hold_valid = 1'b1;
                if (wait_cnt >= ack_delay) begin
                    mem_wr_ack = 1'b1;
                    wr_q.push_back(hold);
                    wait_cnt = 0;
                    hold_valid = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                hold_valid = 1'b0;
            end
        end
    end

    // Judger: answers after judge_delay cycles, holds done until judge_en drops.
    initial begin : judge_model
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (judge_done) begin
                if (!judge_en) judge_done = 1'b0;
            end else if (judge_en) begin
                if (cnt >= judge_delay) begin
                    judge_done   = 1'b1;
                    judge_result = next_result;
                    judge_count++;
                    last_jpos    = judge_pos;
                    last_jcolor  = judge_color;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Handshake invariants sampled just after each rising edge.
    initial begin : inv_mon
        logic prev_jen;
        prev_jen = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (judge_en && mem_wr_en) inv_err++;
            if (judge_en && !prev_jen && judge_done) inv_err++;
            prev_jen = judge_en;
        end
    end

    // k = {up, down, left, right, place, restart}, held for exactly one rising edge.
    task automatic pulse(input logic [5:0] k);
        @(negedge clk);
        {key_up, key_down, key_left, key_right, key_place, key_restart} = k;
        @(negedge clk);
        {key_up, key_down, key_left, key_right, key_place, key_restart} = 6'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input int target, input string name);
        int n;
        n = 0;
        while (wr_q.size() < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(wr_q.size() >= target), 32'd1);
    endtask

    task automatic check_clear(input int start, input string name);
        int bad;
        logic [7:0] exp;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            exp = {6'(i), 2'b00};
            if (start + i >= wr_q.size() || wr_q[start + i] !== exp) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    // One key pulse plus the judge/write handshakes it is expected to trigger.
    task automatic txn(input logic [5:0] k, input logic [1:0] res, input int jd, input int ad,
                       input bit expect_judge);
        int jc0, wc0, n;
        jc0 = judge_count;
        wc0 = wr_q.size();
        next_result = res; judge_delay = jd; ack_delay = ad;
        pulse(k);
        if (expect_judge) begin
            n = 0;
            while (judge_count == jc0 && n < 100) begin @(posedge clk); n++; end
            check("judge_handshake", 32'(judge_count != jc0), 32'd1);
            if (res == JUDGER_VALID || res == JUDGER_WIN) begin
                n = 0;
                while (wr_q.size() == wc0 && n < 100) begin @(posedge clk); n++; end
                check("write_handshake", 32'(wr_q.size() != wc0), 32'd1);
            end
        end
        settle();
    endtask

    typedef struct {
        logic [3:0] keys;     // {up, down, left, right}
        logic [5:0] exp_pos;
    } cur_vec_t;

    cur_vec_t vecs[15];

    initial begin : main
        int mx, my, mside, mstep, mwrites, base, iter, n;
        logic [3:0] mv;
        logic       plc;
        logic [1:0] res;
        logic [5:0] epos;

        vecs[0]  = '{4'b0001, 6'd28};  // right
        vecs[1]  = '{4'b0001, 6'd29};
        vecs[2]  = '{4'b0001, 6'd30};  // 3x right from 27
        vecs[3]  = '{4'b0001, 6'd31};  // x = 7
        vecs[4]  = '{4'b0001, 6'd24};  // x wraps to 0
        vecs[5]  = '{4'b1000, 6'd16};  // up
        vecs[6]  = '{4'b1000, 6'd8};
        vecs[7]  = '{4'b1000, 6'd0};   // y = 0
        vecs[8]  = '{4'b1000, 6'd56};  // y wraps to 7
        vecs[9]  = '{4'b1100, 6'd56};  // up+down cancel
        vecs[10] = '{4'b0011, 6'd56};  // left+right cancel
        vecs[11] = '{4'b0010, 6'd63};  // left wraps x to 7
        vecs[12] = '{4'b0100, 6'd7};   // down wraps y to 0
        vecs[13] = '{4'b0110, 6'd14};  // down+left
        vecs[14] = '{4'b1101, 6'd15};  // up/down cancel, right

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cursor", 32'(cursor_pos), 32'd27);
        check("rst_side", 32'(cur_side), 32'd0);
        check("rst_step", 32'(step_count), 32'd0);
        check("rst_over", 32'(game_over), 32'd0);
        check("rst_winner", 32'(winner), 32'd0);
        check("rst_judge_en", 32'(judge_en), 32'd0);
        check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Initial clear loop.
        wait_writes(64, "clear_done");
        settle();
        check_clear(0, "clear_seq");
        check("clear_count", 32'(wr_q.size()), 32'd64);
        check("play_cursor", 32'(cursor_pos), 32'd27);
        check("play_side", 32'(cur_side), 32'd0);

        // Table-driven cursor moves.
        foreach (vecs[i]) begin
            pulse({vecs[i].keys, 2'b00});
            check($sformatf("cursor_vec%0d", i), 32'(cursor_pos), 32'(vecs[i].exp_pos));
        end

        // Random cursor moves against an arithmetic x/y model.
        mx = int'(vecs[14].exp_pos[2:0]);
        my = int'(vecs[14].exp_pos[5:3]);
        for (int i = 0; i < 30; i++) begin
            mv = 4'($urandom_range(0, 15));
            mx = (mx + int'(mv[0]) - int'(mv[1]) + 8) % 8;
            my = (my + int'(mv[2]) - int'(mv[3]) + 8) % 8;
            pulse({mv, 2'b00});
            check("cursor_rand", 32'(cursor_pos), 32'(my * 8 + mx));
        end

        // Restart in play: immediate reload, then a full clear.
        base = wr_q.size();
        pulse(6'b000001);
        check("restart_cursor", 32'(cursor_pos), 32'd27);
        wait_writes(base + 64, "restart_clear_done");
        settle();
        check_clear(base, "restart_clear_seq");

        // INVALID: no write, nothing changes.
        base = wr_q.size();
        txn(6'b000010, JUDGER_INVALID, 1, 0, 1'b1);
        check("inv_jpos", 32'(last_jpos), 32'd27);
        check("inv_jcolor", 32'(last_jcolor), 32'd0);
        check("inv_no_write", 32'(wr_q.size()), 32'(base));
        check("inv_side", 32'(cur_side), 32'd0);
        check("inv_step", 32'(step_count), 32'd0);

        // VALID red at 27.
        txn(6'b000010, JUDGER_VALID, 0, 0, 1'b1);
        check("valid_write", 32'(wr_q[$]), 32'({6'd27, 2'b10}));
        check("valid_step", 32'(step_count), 32'd1);
        check("valid_side", 32'(cur_side), 32'd1);

        // Green moves right, VALID at 28.
        pulse(6'b000100);
        txn(6'b000010, JUDGER_VALID, 2, 1, 1'b1);
        check("green_write", 32'(wr_q[$]), 32'({6'd28, 2'b01}));
        check("green_step", 32'(step_count), 32'd2);
        check("green_side", 32'(cur_side), 32'd0);

        // Place + right together: judge sees the pre-move cursor, cursor still moves.
        txn(6'b000110, JUDGER_INVALID, 0, 0, 1'b1);
        check("pm_jpos", 32'(last_jpos), 32'd28);
        check("pm_jcolor", 32'(last_jcolor), 32'd0);
        check("pm_cursor", 32'(cursor_pos), 32'd29);

        // Red at 29, then green WIN at 29.
        txn(6'b000010, JUDGER_VALID, 0, 2, 1'b1);
        check("red29_write", 32'(wr_q[$]), 32'({6'd29, 2'b10}));
        txn(6'b000010, JUDGER_WIN, 1, 0, 1'b1);
        check("win_write", 32'(wr_q[$]), 32'({6'd29, 2'b01}));
        check("win_over", 32'(game_over), 32'd1);
        check("win_winner", 32'(winner), 32'd1);
        check("win_step", 32'(step_count), 32'd4);
        check("win_side", 32'(cur_side), 32'd1);

        // Keys ignored once the game is over.
        base = wr_q.size();
        n = judge_count;
        txn(6'b000110, JUDGER_VALID, 0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("over_no_judge", 32'(judge_count), 32'(n));
        check("over_no_write", 32'(wr_q.size()), 32'(base));
        check("over_cursor", 32'(cursor_pos), 32'd29);

        // Restart from game over.
        pulse(6'b000001);
        check("ro_over", 32'(game_over), 32'd0);
        check("ro_winner", 32'(winner), 32'd0);
        check("ro_step", 32'(step_count), 32'd0);
        check("ro_side", 32'(cur_side), 32'd0);
        wait_writes(base + 64, "ro_clear_done");
        settle();
        check_clear(base, "ro_clear_seq");

        // Random game without wins until the board fills (draw).
        mx = 3; my = 3; mside = 0; mstep = 0; mwrites = wr_q.size(); iter = 0;
        while (mstep < 64 && iter < 600) begin
            iter++;
            mv   = 4'($urandom_range(0, 15));
            plc  = ($urandom_range(0, 2) != 0);
            res  = ($urandom_range(0, 4) == 0) ? JUDGER_INVALID : JUDGER_VALID;
            epos = 6'(my * 8 + mx);
            mx = (mx + int'(mv[0]) - int'(mv[1]) + 8) % 8;
            my = (my + int'(mv[2]) - int'(mv[3]) + 8) % 8;
            txn({mv, plc, 1'b0}, res, $urandom_range(0, 3), $urandom_range(0, 3), plc);
            if (plc) begin
                check("rg_jpos", 32'(last_jpos), 32'(epos));
                check("rg_jcolor", 32'(last_jcolor), 32'(mside));
                if (res == JUDGER_VALID) begin
                    mwrites++;
                    mstep++;
                    check("rg_write", 32'(wr_q[$]), 32'({epos, (mside != 0) ? 2'b01 : 2'b10}));
                    if (mstep < 64) mside = 1 - mside;
                end
            end
            check("rg_writes", 32'(wr_q.size()), 32'(mwrites));
            check("rg_cursor", 32'(cursor_pos), 32'(my * 8 + mx));
            check("rg_step", 32'(step_count), 32'(mstep));
            check("rg_side", 32'(cur_side), 32'(mside));
        end
        check("draw_step", 32'(step_count), 32'd64);
        check("draw_over", 32'(game_over), 32'd1);
        check("draw_winner", 32'(winner), 32'd0);

        // Restart, then restart during judge with a slow write ack.
        base = wr_q.size();
        pulse(6'b000001);
        wait_writes(base + 64, "d_clear_done");
        settle();
        base = wr_q.size();
        n = judge_count;
        next_result = JUDGER_VALID; judge_delay = 3; ack_delay = 3;
        pulse(6'b000010);
        check("rj_judge_en", 32'(judge_en), 32'd1);
        pulse(6'b000001);
        wait_writes(base + 65, "rj_clear_done");
        settle();
        check("rj_judged", 32'(judge_count), 32'(n + 1));
        check("rj_write", 32'(wr_q[base]), 32'({6'd27, 2'b10}));
        check_clear(base + 1, "rj_clear_seq");
        check("rj_step", 32'(step_count), 32'd0);
        check("rj_side", 32'(cur_side), 32'd0);
        check("rj_cursor", 32'(cursor_pos), 32'd27);
        check("rj_over", 32'(game_over), 32'd0);

        // Asynchronous reset in the middle of a write.
        next_result = JUDGER_VALID; judge_delay = 0; ack_delay = 8;
        pulse(6'b001010);
        n = 0;
        while (!mem_wr_en && n < 100) begin @(posedge clk); n++; end
        check("ar_write_seen", 32'(mem_wr_en), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_mem_wr_en", 32'(mem_wr_en), 32'd0);
        check("ar_judge_en", 32'(judge_en), 32'd0);
        check("ar_cursor", 32'(cursor_pos), 32'd27);
        ack_delay = 0;
        @(negedge clk);
        base = wr_q.size();
        rst_n = 1'b1;
        wait_writes(base + 64, "ar_clear_done");
        settle();
        check_clear(base, "ar_clear_seq");

        check("wr_stable", 32'(stable_err), 32'd0);
        check("handshake_inv", 32'(inv_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
